// File: rtl/branch_redirect_ctrl_pkg.sv
// rtl/branch_redirect_ctrl_pkg.sv - shared widths and redirect FSM state type
package branch_redirect_ctrl_pkg;

    localparam int RV_NB_ADDR    = 32;
    localparam int RV_NB_OPERAND = 5;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_REDIRECT,
        RD_DRAIN
    } redirect_state_t;

    // Instruction fetch requires 4-byte aligned targets.
    function automatic logic is_misaligned(input logic [1:0] i_lsb);
        return (i_lsb != 2'b00);
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - EX-resolved control-flow redirect, flush drain and link write-back
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int NB_ADDR      = RV_NB_ADDR,
    parameter int NB_OPERAND   = RV_NB_OPERAND,
    parameter int FLUSH_CYCLES = 2,
    parameter int NB_CNT       = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_ex_valid,
    input  logic                  i_branch_taken,
    input  logic [NB_ADDR-1:0]    i_branch_addr,
    input  logic                  i_wr_retaddr,
    input  logic [NB_OPERAND-1:0] i_rd_retaddr,
    input  logic [NB_ADDR-1:0]    i_ret_addr,
    input  logic                  i_fetch_ready,
    output logic                  o_redirect_valid,
    output logic [NB_ADDR-1:0]    o_redirect_addr,
    output logic                  o_flush,
    output logic                  o_stall_ex,
    output logic                  o_misaligned,
    output logic                  o_rd_we,
    output logic [NB_OPERAND-1:0] o_rd_addr,
    output logic [NB_ADDR-1:0]    o_rd_data,
    output logic [NB_CNT-1:0]     o_taken_count
);

    localparam logic [3:0] DRAIN_LOAD = (FLUSH_CYCLES == 0) ? 4'd0 : 4'(FLUSH_CYCLES - 1);

    redirect_state_t         r_state;
    redirect_state_t         w_state_next;
    logic [3:0]              r_drain_cnt;
    logic [3:0]              w_drain_cnt_next;
    logic [NB_ADDR-1:0]      r_target;
    logic                    r_misaligned;
    logic                    r_rd_we;
    logic [NB_OPERAND-1:0]   r_rd_addr;
    logic [NB_ADDR-1:0]      r_rd_data;
    logic [NB_CNT-1:0]       r_taken_count;

    logic w_idle;
    logic w_capture;
    logic w_aligned;
    logic w_link;
    logic w_handshake;

    // New EX events are only accepted while idle; EX is stalled otherwise.
    assign w_idle      = (r_state == RD_IDLE);
    assign w_capture   = w_idle & i_ex_valid & i_branch_taken;
    assign w_aligned   = ~is_misaligned(i_branch_addr[1:0]);
    assign w_link      = w_idle & i_ex_valid & i_wr_retaddr;
    assign w_handshake = (r_state == RD_REDIRECT) & i_fetch_ready;

    always_comb begin
        w_state_next     = r_state;
        w_drain_cnt_next = r_drain_cnt;
        case (r_state)
            RD_IDLE: begin
                if (w_capture && w_aligned) begin
                    w_state_next = RD_REDIRECT;
                end
            end
            RD_REDIRECT: begin
                if (i_fetch_ready) begin
                    if (FLUSH_CYCLES == 0) begin
                        w_state_next = RD_IDLE;
                    end else begin
                        w_state_next     = RD_DRAIN;
                        w_drain_cnt_next = DRAIN_LOAD;
                    end
                end
            end
            RD_DRAIN: begin
                if (r_drain_cnt == 4'd0) begin
                    w_state_next = RD_IDLE;
                end else begin
                    w_drain_cnt_next = r_drain_cnt - 4'd1;
                end
            end
            default: begin
                w_state_next = RD_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= RD_IDLE;
            r_drain_cnt   <= '0;
            r_target      <= '0;
            r_misaligned  <= 1'b0;
            r_rd_we       <= 1'b0;
            r_rd_addr     <= '0;
            r_rd_data     <= '0;
            r_taken_count <= '0;
        end else begin
            r_state      <= w_state_next;
            r_drain_cnt  <= w_drain_cnt_next;
            if (w_capture && w_aligned) begin
                r_target <= i_branch_addr;
            end
            r_misaligned <= w_capture & ~w_aligned;
            // Link write is independent of target alignment; x0 is never written.
            r_rd_we      <= w_link & (i_rd_retaddr != '0);
            r_rd_addr    <= w_link ? i_rd_retaddr : '0;
            r_rd_data    <= w_link ? i_ret_addr : '0;
            if (w_handshake) begin
                r_taken_count <= r_taken_count + NB_CNT'(1);
            end
        end
    end

    assign o_redirect_valid = (r_state == RD_REDIRECT);
    assign o_redirect_addr  = r_target;
    assign o_flush          = ~w_idle;
    assign o_stall_ex       = ~w_idle;
    assign o_misaligned     = r_misaligned;
    assign o_rd_we          = r_rd_we;
    assign o_rd_addr        = r_rd_addr;
    assign o_rd_data        = r_rd_data;
    assign o_taken_count    = r_taken_count;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb/tb_branch_redirect_ctrl.sv - scoreboard bench for branch_redirect_ctrl
module tb_branch_redirect_ctrl;

    localparam int FLUSH = 2;
    localparam int NCNT  = 8;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_ex_valid = 1'b0;
    logic        i_branch_taken = 1'b0;
    logic [31:0] i_branch_addr = '0;
    logic        i_wr_retaddr = 1'b0;
    logic [4:0]  i_rd_retaddr = '0;
    logic [31:0] i_ret_addr = '0;
    logic        i_fetch_ready = 1'b0;
    logic        o_redirect_valid;
    logic [31:0] o_redirect_addr;
    logic        o_flush;
    logic        o_stall_ex;
    logic        o_misaligned;
    logic        o_rd_we;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;
    logic [NCNT-1:0] o_taken_count;

    branch_redirect_ctrl #(
        .NB_ADDR(32), .NB_OPERAND(5), .FLUSH_CYCLES(FLUSH), .NB_CNT(NCNT)
    ) dut (
        .i_clock(clk), .i_reset(i_reset), .i_ex_valid(i_ex_valid),
        .i_branch_taken(i_branch_taken), .i_branch_addr(i_branch_addr),
        .i_wr_retaddr(i_wr_retaddr), .i_rd_retaddr(i_rd_retaddr), .i_ret_addr(i_ret_addr),
        .i_fetch_ready(i_fetch_ready), .o_redirect_valid(o_redirect_valid),
        .o_redirect_addr(o_redirect_addr), .o_flush(o_flush), .o_stall_ex(o_stall_ex),
        .o_misaligned(o_misaligned), .o_rd_we(o_rd_we), .o_rd_addr(o_rd_addr),
        .o_rd_data(o_rd_data), .o_taken_count(o_taken_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; bit busy; bit req; int count; } status_t;
    typedef struct { int cyc; logic [4:0] rd; logic [31:0] data; } link_t;

    status_t     st_q[$];
    link_t       link_q[$];
    int          mis_q[$];
    logic [31:0] redir_q[$];

    int tests = 0;
    int fails = 0;

    // Reference model: pending redirect flag plus remaining drain cycles.
    bit m_pending = 0;
    int m_drain   = 0;
    int m_count   = 0;

    task automatic chk(input string nm, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
        end
    endtask

    task automatic drive(input bit exv, input bit tk, input logic [31:0] addr, input bit wr,
                         input logic [4:0] rd, input logic [31:0] ret, input bit fr, input bit rst);
        bit idle;
        status_t s;
        link_t l;
        i_ex_valid = exv; i_branch_taken = tk; i_branch_addr = addr;
        i_wr_retaddr = wr; i_rd_retaddr = rd; i_ret_addr = ret;
        i_fetch_ready = fr; i_reset = rst;
        if (rst) begin
            m_pending = 0; m_drain = 0; m_count = 0;
        end else begin
            idle = !m_pending && (m_drain == 0);
            if (m_pending) begin
                if (fr) begin
                    m_pending = 0;
                    m_drain   = FLUSH;
                    m_count   = (m_count + 1) % (1 << NCNT);
                end
            end else if (m_drain > 0) begin
                m_drain--;
            end
            if (idle && exv && tk) begin
                if (addr % 4 == 0) begin
                    redir_q.push_back(addr);
                    m_pending = 1;
                end else begin
                    mis_q.push_back(cyc + 1);
                end
            end
            if (idle && exv && wr && rd != 0) begin
                l.cyc = cyc + 1; l.rd = rd; l.data = ret;
                link_q.push_back(l);
            end
        end
        s.cyc = cyc + 1; s.req = m_pending; s.busy = m_pending || (m_drain > 0); s.count = m_count;
        st_q.push_back(s);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n, input bit fr);
        for (int k = 0; k < n; k++) drive(0, 0, 32'h0, 0, 5'd0, 32'h0, fr, 0);
    endtask

    status_t ms;
    link_t   ml;

    always @(negedge clk) begin
        while (st_q.size() > 0 && st_q[0].cyc < cyc) begin
            chk("status_missed", st_q[0].cyc, cyc);
            void'(st_q.pop_front());
        end
        if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
            ms = st_q.pop_front();
            chk("redirect_valid", o_redirect_valid, ms.req);
            chk("flush", o_flush, ms.busy);
            chk("stall_ex", o_stall_ex, ms.busy);
            chk("taken_count", o_taken_count, ms.count);
        end
        if (o_redirect_valid) begin
            if (redir_q.size() == 0) begin
                chk("redirect_unexpected", 1, 0);
            end else begin
                chk("redirect_addr", o_redirect_addr, redir_q[0]);
                if (i_fetch_ready || i_reset) void'(redir_q.pop_front());
            end
        end
        while (link_q.size() > 0 && link_q[0].cyc < cyc) begin
            chk("link_missed", link_q[0].cyc, cyc);
            void'(link_q.pop_front());
        end
        if (o_rd_we) begin
            if (link_q.size() > 0 && link_q[0].cyc == cyc) begin
                ml = link_q.pop_front();
                chk("rd_addr", o_rd_addr, ml.rd);
                chk("rd_data", o_rd_data, ml.data);
            end else begin
                chk("rd_we_unexpected", 1, 0);
            end
        end
        while (mis_q.size() > 0 && mis_q[0] < cyc) begin
            chk("misaligned_missed", mis_q[0], cyc);
            void'(mis_q.pop_front());
        end
        if (o_misaligned) begin
            if (mis_q.size() > 0 && mis_q[0] == cyc) void'(mis_q.pop_front());
            else chk("misaligned_unexpected", 1, 0);
        end
    end

    logic [31:0] ra;
    logic [31:0] rr;

    initial begin
        @(posedge clk); #1;
        drive(0, 0, 32'h0, 0, 5'd0, 32'h0, 1, 1);
        @(negedge clk); #1;
        chk("reset_redirect_addr", o_redirect_addr, 0);
        chk("reset_misaligned", o_misaligned, 0);
        chk("reset_rd_we", o_rd_we, 0);
        chk("reset_rd_addr", o_rd_addr, 0);
        chk("reset_rd_data", o_rd_data, 0);
        @(posedge clk); #1;

        // Basic redirect with immediate fetch acceptance.
        drive(1, 1, 32'h0000_0100, 0, 5'd0, 32'h0, 1, 0);
        idle_cycles(4, 1);
        // Fetch back-pressure for three cycles.
        drive(1, 1, 32'h0000_0200, 0, 5'd0, 32'h0, 0, 0);
        idle_cycles(3, 0);
        idle_cycles(4, 1);
        // JAL with link write, then the same with rd=0.
        drive(1, 1, 32'h0000_0080, 1, 5'd1, 32'h0000_0104, 1, 0);
        idle_cycles(4, 1);
        drive(1, 1, 32'h0000_0080, 1, 5'd0, 32'h0000_0104, 1, 0);
        idle_cycles(4, 1);
        // Misaligned target, with and without a link write.
        drive(1, 1, 32'h0000_0102, 0, 5'd0, 32'h0, 1, 0);
        idle_cycles(2, 1);
        drive(1, 1, 32'h0000_0103, 1, 5'd7, 32'h0000_0abc, 1, 0);
        idle_cycles(2, 1);
        // Taken without ex_valid, and not-taken with fetch_ready asserted.
        drive(0, 1, 32'h0000_0400, 1, 5'd3, 32'h1, 1, 0);
        drive(1, 0, 32'h0000_0400, 0, 5'd0, 32'h0, 1, 0);
        idle_cycles(2, 1);
        // Reset while a redirect is pending.
        drive(1, 1, 32'h0000_0300, 0, 5'd0, 32'h0, 0, 0);
        drive(0, 0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
        drive(0, 0, 32'h0, 0, 5'd0, 32'h0, 1, 1);
        idle_cycles(3, 1);
        // Back-to-back redirects with ignored events during REDIRECT/DRAIN; wraps the counter.
        for (int n = 0; n < 260; n++) begin
            ra = $urandom; ra[1:0] = 2'b00;
            rr = $urandom;
            drive(1, 1, ra, 1, 5'd9, rr, 1, 0);
            for (int k = 0; k < 3; k++) begin
                rr = $urandom;
                drive(1, 1, rr & 32'hffff_fffc, 1, 5'd5, rr, 1, 0);
            end
        end
        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            ra = $urandom;
            if ($urandom % 4 != 0) ra[1:0] = 2'b00;
            rr = $urandom;
            drive($urandom % 4 != 0, $urandom % 2 == 0, ra, $urandom % 3 == 0,
                  ($urandom % 4 == 0) ? 5'd0 : 5'($urandom_range(1, 31)), rr,
                  $urandom % 3 != 0, $urandom % 500 == 0);
        end
        idle_cycles(8, 1);
        @(negedge clk); #1;
        chk("status_queue_drained", st_q.size(), 0);
        chk("redirect_queue_drained", redir_q.size(), 0);
        chk("link_queue_drained", link_q.size(), 0);
        chk("misaligned_queue_drained", mis_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
